rr_select_arbiter: RTL and testbench
====================================

# rr_select_arbiter

Round-robin arbiter that shares one `DATA`-bit output channel among `IN` requesters, built around the team's `selector` in bitmap mode. It sequences the selector's bitmap so that each beat's winner comes from a rotating priority. Multi-beat packets hold the grant until their last beat. The chosen beat goes into a registered valid/ready output stage.

## Interface
- `DATA`, 32, width of one data word
- `IN`, 4, number of requesters (≥2)
- `clk` input 1 — sole clock, rising edge
- `reset` input 1 — synchronous, active-high reset
- `req_valid` input IN — requester i has a beat on `req_data[DATA*i +: DATA]`
- `req_data` input DATA*IN — packed requester data, requester i at `[DATA*i +: DATA]`
- `req_last` input IN — bit i marks requester i's current beat as the last beat of its packet
- `req_ready` output IN — one-hot (or zero); beat from requester i is accepted this cycle
- `out_valid` output 1 — output register holds a beat
- `out_data` output DATA — registered winning data
- `out_src` output IN — one-hot source of `out_data`
- `out_last` output 1 — registered copy of winner's `req_last`
- `out_ready` input 1 — downstream accepts `out_*` this cycle

## Operation
- State: `ptr` (IN-bit one-hot, last requester granted a completed packet), `lock` (1 bit), `owner` (IN-bit one-hot), output register.
- `load = !out_valid || out_ready`. No beat is accepted when `load` = 0.
- Arbitration when `lock` = 0:
  - `hi_mask` = bits strictly above `ptr`.
  - `cand` = `req_valid & hi_mask` if nonzero, else `req_valid`.
  - `grant` = lowest set bit of `cand`. This is `selector` with ACT=High and MSB=Disable in bitmap mode, so its `pos` output is the grant.
- Arbitration when `lock` = 1: `grant = owner & req_valid`. Other requesters are never granted while locked.
- Data path: `out_data` = `selector.out` from `req_data` under the `grant` bitmap. `out_last` = OR of `req_last & grant`.
- `req_ready = grant` when `load` = 1, else all zeros. Transfer of requester i ⇔ `req_valid[i] & req_ready[i]`.
- On a transfer, at the next rising edge:
  - `out_valid` = 1, `out_data`, `out_src = grant`, `out_last` are updated.
  - If the beat is not last: `lock` = 1 and `owner` = grant.
  - If the beat is last: `lock` = 0 and `ptr` = grant.
- No transfer and `out_ready` = 1: `out_valid` goes to 0. `out_data`, `out_src` and `out_last` hold their values.
- State machine:
  - IDLE (`lock` = 0) → LOCKED on acceptance of a non-last beat.
  - LOCKED → IDLE on acceptance of the owner's last beat.
  - LOCKED → LOCKED while the owner is idle (`req_valid[owner]` = 0) or while the output stalls.
- Single-beat packets: `req_last` = 1 on every beat. Each accepted beat then rotates `ptr`, which gives pure round-robin.

## Timing
- Reset values (synchronous, take effect at the first edge with `reset` = 1):
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `out_last` = 0.
  - `lock` = 0, `owner` = 0.
  - `ptr` = one-hot bit IN-1, so requester 0 has first priority.
  - `req_ready` = 0 while `reset` = 1.
- Latency: a beat accepted in cycle N appears on `out_*` in cycle N+1.
- Throughput: one beat per cycle when `out_ready` is held at 1. The output register refills in the same cycle it drains.
- `req_ready` is combinational from `req_valid`, state, `out_valid` and `out_ready`. It does not depend on `req_data` or `req_last`.
- Output stall (`out_valid` = 1, `out_ready` = 0): all `out_*` hold, `req_ready` = 0, and arbitration state is frozen.
- `ptr` wrap-around: when `ptr` = bit IN-1, `hi_mask` = 0 and arbitration falls back to the lowest set bit of `req_valid`.
- A requester that deasserts `req_valid` before `req_ready` may lose its turn. No fairness credit is kept.
- `reset` asserted mid-packet: lock is dropped and `out_valid` is cleared on that edge. The partial packet is not completed.
- `req_valid` = 0: no grant, `req_ready` = 0. `out_valid` clears after an `out_ready` handshake.

## Test plan
Common setup for all scenarios: IN=4, DATA=32, `req_data[32*i +: 32] = i+1`, `out_ready` = 1 unless stated.
- Reset check: hold `reset` 2 cycles with all `req_valid` = 1 → `req_ready` = 0, `out_valid` = 0, `out_data` = 0. First beat after release comes from requester 0.
- Round-robin rotation: `req_valid` = 4'b1111, `req_last` = 4'b1111, 8 cycles → `out_data` = 1,2,3,4,1,2,3,4 and `out_src` = 0001,0010,0100,1000,… at one beat per cycle.
- Sparse requests and wrap-around:
  - Step 1: `req_valid` = 4'b1010 → `out_data` sequence 2,4,2,4.
  - Step 2: after the grant to 4, switch to `req_valid` = 4'b0011 → next beat is 1, then 2.
- Packet lock: requester 1 sends 3 beats with `req_last` = 0,0,1 while requesters 0, 2 and 3 are valid.
  - Required: three consecutive `out_src` = 0010 with `out_last` = 0,0,1, then requester 2.
  - Drop `req_valid[1]` for 2 cycles mid-packet → `req_ready` = 0 for everyone during those cycles and `out_valid` falls.
- Backpressure: with `req_valid` = 4'b1111, hold `out_ready` = 0 for 3 cycles after the first beat.
  - Required: `out_data` = 1 holds and `req_ready` = 0. On release the sequence continues 2,3,4 with no beat lost or duplicated.
- Reset mid-packet: assert `reset` one cycle during a locked packet from requester 2 (`ptr` = 0010).
  - Required: `out_valid` = 0 next cycle, lock cleared, and arbitration restarts at requester 0 while `req_valid` = 4'b1111.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter sharing one DATA-bit channel among IN requesters.
// Packets hold the grant until their last beat; the winner lands in a registered valid/ready stage.

module selector #(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter bit ACT = 1'b1,   // 1: bitmap bits are active high
    parameter bit MSB = 1'b0    // 1: highest set bit wins, 0: lowest
) (
    input  logic [N-1:0]   map,
    input  logic [W*N-1:0] in,
    output logic [N-1:0]   pos,
    output logic [W-1:0]   out
);
    logic [N-1:0] act;
    logic         found;

    assign act = ACT ? map : ~map;

    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (act[MSB ? N-1-k : k] && !found) begin
                pos[MSB ? N-1-k : k] = 1'b1;
                found                = 1'b1;
            end
        end
    end

    // AND-OR mux; pos is one-hot or zero so at most one lane contributes
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++)
            out = out | (in[W*i +: W] & {W{pos[i]}});
    end
endmodule

module rr_select_arbiter #(
    parameter int DATA = 32,
    parameter int IN   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN-1:0]     req_valid,
    input  logic [DATA*IN-1:0] req_data,
    input  logic [IN-1:0]     req_last,
    output logic [IN-1:0]     req_ready,
    output logic              out_valid,
    output logic [DATA-1:0]   out_data,
    output logic [IN-1:0]     out_src,
    output logic              out_last,
    input  logic              out_ready
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [IN-1:0]   ptr, owner;
    logic [IN-1:0]   hi_mask, hi_req, cand, grant;
    logic [DATA-1:0] sel_data;
    logic            load, xfer, beat_last, lock;

    assign lock    = (state == LOCKED);
    assign load    = !out_valid || out_ready;
    assign hi_mask = ~(ptr | (ptr - IN'(1)));
    assign hi_req  = req_valid & hi_mask;

    // While locked the candidate set is just the owner, so the selector passes it through
    always_comb begin
        cand = '0;
        if (lock)
            cand = owner & req_valid;
        else if (|hi_req)
            cand = hi_req;
        else
            cand = req_valid;
    end

    selector #(.W(DATA), .N(IN), .ACT(1'b1), .MSB(1'b0)) u_sel (
        .map (cand),
        .in  (req_data),
        .pos (grant),
        .out (sel_data)
    );

    assign req_ready = (load && !reset) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign beat_last = |(req_last & grant);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !beat_last) state_nxt = LOCKED;
            LOCKED:  if (xfer && beat_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
            ptr       <= {1'b1, {(IN-1){1'b0}}};
            owner     <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant;
            out_last  <= beat_last;
            if (beat_last)
                ptr   <= grant;
            else
                owner <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: reset, rotation, wrap, packet lock, mid-packet reset, backpressure.

module tb_rr_select_arbiter;
    localparam int DATA = 32;
    localparam int IN   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [IN-1:0]     req_valid, req_last, req_ready, out_src;
    logic [DATA*IN-1:0] req_data;
    logic              out_valid, out_last, out_ready;
    logic [DATA-1:0]   out_data;

    int n_chk  = 0;
    int n_fail = 0;

    rr_select_arbiter #(.DATA(DATA), .IN(IN)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // check one output beat: data, source, last
    task automatic beat(input string tag, input int d, input logic [IN-1:0] src, input logic lst);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".src"},   64'(out_src),   64'(src));
        chk({tag, ".last"},  64'(out_last),  64'(lst));
    endtask

    initial begin
        for (int i = 0; i < IN; i++) req_data[DATA*i +: DATA] = DATA'(i + 1);
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 64'(req_ready), 64'(0));
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.data",  64'(out_data),  64'(0));
        reset = 1'b0;
        #1 chk("rst.first_ready", 64'(req_ready), 64'(4'b0001));

        // round robin, one beat per cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            beat($sformatf("rr%0d", k), (k % 4) + 1, 4'(1 << (k % 4)), 1'b1);
        end

        // sparse requests with wrap-around; ptr is at requester 3
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            beat($sformatf("sp%0d", k), (k % 2) ? 4 : 2, (k % 2) ? 4'b1000 : 4'b0010, 1'b1);
        end
        req_valid = 4'b0011;
        @(negedge clk); beat("sw0", 1, 4'b0001, 1'b1);
        @(negedge clk); beat("sw1", 2, 4'b0010, 1'b1);

        // move ptr to requester 0 so requester 1 wins next
        req_valid = 4'b0001;
        #1 chk("pk.pre_ready", 64'(req_ready), 64'(4'b0001));
        @(negedge clk); beat("pk.pre", 1, 4'b0001, 1'b1);

        // packet lock: requester 1 sends 3 beats, drops valid for 2 cycles mid-packet
        req_valid = 4'b1111;
        req_last  = 4'b1101;
        #1 chk("pk.ready0", 64'(req_ready), 64'(4'b0010));
        @(negedge clk); beat("pk.b0", 2, 4'b0010, 1'b0);
        #1 chk("pk.ready1", 64'(req_ready), 64'(4'b0010));
        @(negedge clk); beat("pk.b1", 2, 4'b0010, 1'b0);
        req_valid = 4'b1101;
        #1 chk("pk.gap_ready0", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("pk.gap_valid0", 64'(out_valid), 64'(0));
        chk("pk.gap_ready1", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("pk.gap_valid1", 64'(out_valid), 64'(0));
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1 chk("pk.ready2", 64'(req_ready), 64'(4'b0010));
        @(negedge clk); beat("pk.b2", 2, 4'b0010, 1'b1);
        #1 chk("pk.next_ready", 64'(req_ready), 64'(4'b0100));

        // requester 2 starts a packet (ptr = requester 1), then reset mid-packet
        req_last = 4'b1011;
        @(negedge clk); beat("mr.b0", 3, 4'b0100, 1'b0);
        req_last = 4'b1111;
        #1 chk("mr.locked_ready", 64'(req_ready), 64'(4'b0100));
        reset = 1'b1;
        #1 chk("mr.rst_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("mr.valid", 64'(out_valid), 64'(0));
        chk("mr.data",  64'(out_data),  64'(0));
        reset = 1'b0;
        #1 chk("mr.restart_ready", 64'(req_ready), 64'(4'b0001));

        // backpressure after the first beat
        @(negedge clk); beat("bp.b0", 1, 4'b0001, 1'b1);
        out_ready = 1'b0;
        #1 chk("bp.ready_stall", 64'(req_ready), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            beat($sformatf("bp.hold%0d", k), 1, 4'b0001, 1'b1);
            chk($sformatf("bp.ready%0d", k), 64'(req_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1 chk("bp.release_ready", 64'(req_ready), 64'(4'b0010));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            beat($sformatf("bp.b%0d", k + 1), k + 2, 4'(1 << (k + 1)), 1'b1);
        end

        // no requests: output drains, data holds
        req_valid = 4'b0000;
        #1 chk("dr.ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("dr.valid", 64'(out_valid), 64'(0));
        chk("dr.data",  64'(out_data),  64'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
